// File: rtl/timestamp_pkg.sv
// Shared definitions for the multi-channel timestamp capture unit:
// edge-mode encodings and the channel-index width helper.
package timestamp_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edgeMode_e;

  // A single channel still needs one index bit on the output port.
  function automatic int chanWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ts_edge_sync.sv
// Per-channel latch input conditioning: multi-flop synchroniser, edge detect
// against the previous synchronised value, and edge-mode qualification.
module ts_edge_sync
  import timestamp_pkg::*;
#(
  parameter int pSYNC = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iLatch,
  input  logic [1:0] iMode,
  output logic       oRise,
  output logic       oFall
);

  logic [pSYNC-1:0] syncQ;
  logic             prevQ;
  logic             riseDet;
  logic             fallDet;

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    riseDet = 1'b0;
    fallDet = 1'b0;
    if (syncQ[pSYNC-1] && !prevQ)
      riseDet = (iMode == EDGE_RISE) || (iMode == EDGE_BOTH);
    if (!syncQ[pSYNC-1] && prevQ)
      fallDet = (iMode == EDGE_FALL) || (iMode == EDGE_BOTH);
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      syncQ <= '0;
      prevQ <= 1'b0;
      oRise <= 1'b0;
      oFall <= 1'b0;
    end else begin
      syncQ <= {syncQ[pSYNC-2:0], iLatch};
      prevQ <= syncQ[pSYNC-1];
      oRise <= riseDet;
      oFall <= fallDet;
    end
  end

endmodule

// File: rtl/timestamp_capture.sv
// Multi-channel timestamp capture: free-running counter sampled on latch
// edges, per-channel pending captures drained round-robin over valid/ready.
module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int pWIDTH    = 40,
  parameter int pCHANNELS = 4,
  parameter int pSYNC     = 2
) (
  input  logic                                iCLK,
  input  logic                                iRST,
  input  logic                                iEnable,
  input  logic                                iClear,
  input  logic [pCHANNELS-1:0]                iLatch,
  input  logic [2*pCHANNELS-1:0]              iEdgeMode,
  output logic [pWIDTH-1:0]                   oCount,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [chanWidth(pCHANNELS)-1:0]     oChannel,
  output logic [pWIDTH-1:0]                   oStamp,
  output logic                                oEdge,
  output logic [pCHANNELS-1:0]                oOverrun,
  input  logic [pCHANNELS-1:0]                iOverrunClr
);

  localparam int cChW = chanWidth(pCHANNELS);

  logic [pWIDTH-1:0]    count;
  logic [pCHANNELS-1:0] riseHit;
  logic [pCHANNELS-1:0] fallHit;
  logic [pCHANNELS-1:0] hit;
  logic [pCHANNELS-1:0] pending;
  logic [pCHANNELS-1:0] drain;
  logic [pCHANNELS-1:0] ovSet;
  logic [pWIDTH-1:0]    capStamp [pCHANNELS];
  logic [pCHANNELS-1:0] capEdge;
  logic [cChW-1:0]      lastGrant;
  logic [cChW-1:0]      grant;
  logic [cChW-1:0]      cand;
  logic                 anyPending;
  logic                 loadOut;

  always_ff @(posedge iCLK) begin
    if (iRST)         count <= '0;
    else if (iClear)  count <= '0;
    else if (iEnable) count <= count + pWIDTH'(1);
  end

  assign oCount = count;

  for (genvar gCh = 0; gCh < pCHANNELS; gCh++) begin : gEdge
    ts_edge_sync #(.pSYNC(pSYNC)) uEdgeSync (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iLatch (iLatch[gCh]),
      .iMode  (iEdgeMode[2*gCh +: 2]),
      .oRise  (riseHit[gCh]),
      .oFall  (fallHit[gCh])
    );
  end

  assign hit     = riseHit | fallHit;
  assign loadOut = !oValid || iReady;

  // Round-robin: first pending channel after the last one granted, wrapping.
  always_comb begin
    grant      = lastGrant;
    cand       = '0;
    anyPending = 1'b0;
    for (int i = 1; i <= pCHANNELS; i++) begin
      cand = cChW'((int'(lastGrant) + i) % pCHANNELS);
      if (!anyPending && pending[cand]) begin
        anyPending = 1'b1;
        grant      = cand;
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int n = 0; n < pCHANNELS; n++)
      drain[n] = loadOut && anyPending && (grant == cChW'(n));
  end

  // A channel draining this cycle frees its slot for a same-cycle capture.
  assign ovSet = hit & pending & ~drain;

  // NOTE: the capture array is cleared on reset so a stale stamp can never
  // reach the output port after a reset.
  always_ff @(posedge iCLK) begin
    for (int n = 0; n < pCHANNELS; n++) begin
      if (iRST) begin
        pending[n]  <= 1'b0;
        capStamp[n] <= '0;
        capEdge[n]  <= 1'b0;
      end else if (hit[n] && (!pending[n] || drain[n])) begin
        pending[n]  <= 1'b1;
        capStamp[n] <= count;
        capEdge[n]  <= riseHit[n];
      end else if (drain[n]) begin
        pending[n]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) oOverrun <= '0;
    else      oOverrun <= (oOverrun & ~iOverrunClr) | ovSet;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oValid    <= 1'b0;
      oChannel  <= '0;
      oStamp    <= '0;
      oEdge     <= 1'b0;
      lastGrant <= cChW'(pCHANNELS - 1);
    end else if (loadOut) begin
      oValid <= anyPending;
      if (anyPending) begin
        oChannel  <= grant;
        oStamp    <= capStamp[grant];
        oEdge     <= capEdge[grant];
        lastGrant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture (8-bit counter, 4 channels, 2-flop sync)
// with a cycle-level reference model compared on every falling edge.
module tb_timestamp_capture;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int S   = 2;
  localparam int CHW = timestamp_pkg::chanWidth(N);
  localparam int HL  = 4096;

  logic           iCLK = 1'b0;
  logic           iRST = 1'b1;
  logic           iEnable = 1'b0;
  logic           iClear = 1'b0;
  logic [N-1:0]   iLatch = '0;
  logic [2*N-1:0] iEdgeMode = '0;
  logic           iReady = 1'b0;
  logic [N-1:0]   iOverrunClr = '0;
  logic [W-1:0]   oCount;
  logic           oValid;
  logic [CHW-1:0] oChannel;
  logic [W-1:0]   oStamp;
  logic           oEdge;
  logic [N-1:0]   oOverrun;

  int nTests = 0;
  int nFail  = 0;

  timestamp_capture #(.pWIDTH(W), .pCHANNELS(N), .pSYNC(S)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iEnable     (iEnable),
    .iClear      (iClear),
    .iLatch      (iLatch),
    .iEdgeMode   (iEdgeMode),
    .oCount      (oCount),
    .oValid      (oValid),
    .iReady      (iReady),
    .oChannel    (oChannel),
    .oStamp      (oStamp),
    .oEdge       (oEdge),
    .oOverrun    (oOverrun),
    .iOverrunClr (iOverrunClr)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are derived from the history of sampled latch values: an edge on
  // a sample taken at edge e is reported as a pulse at edge e+S and captured
  // (with the counter value of that pulse cycle) one edge later.
  logic [N-1:0] samp [HL];
  int           mEdgeNo    = 0;
  int           resetEdge  = -1;
  bit           mArmed     = 1'b0;
  logic [W-1:0] mCount;
  logic [N-1:0] mPend, mPR, mPF, mOv, mCapE, nR, nF, s1, s0;
  logic [W-1:0] mCapS [N];
  logic         mValid, mEdgeT;
  int           mChan, mLastGrant, g;
  logic [W-1:0] mStamp;
  bit           anyP, load, h, drn, setOv;

  function automatic logic [N-1:0] sampleAt(input int e);
    if (e <= resetEdge || e < 0) return '0;
    return samp[e % HL];
  endfunction

  always @(posedge iCLK) begin
    mEdgeNo++;
    samp[mEdgeNo % HL] = iLatch;
    if (iRST) begin
      resetEdge  = mEdgeNo;
      mArmed     = 1'b1;
      mCount     = '0;
      mPend      = '0;
      mPR        = '0;
      mPF        = '0;
      mOv        = '0;
      mCapE      = '0;
      for (int n = 0; n < N; n++) mCapS[n] = '0;
      mValid     = 1'b0;
      mEdgeT     = 1'b0;
      mChan      = 0;
      mStamp     = '0;
      mLastGrant = N - 1;
    end else begin
      load = !mValid || iReady;
      anyP = 1'b0;
      g    = 0;
      for (int i = 1; i <= N; i++)
        if (!anyP && mPend[(mLastGrant + i) % N]) begin
          anyP = 1'b1;
          g    = (mLastGrant + i) % N;
        end
      if (load) begin
        mValid = anyP;
        if (anyP) begin
          mChan      = g;
          mStamp     = mCapS[g];
          mEdgeT     = mCapE[g];
          mLastGrant = g;
        end
      end
      for (int n = 0; n < N; n++) begin
        h     = mPR[n] || mPF[n];
        drn   = load && anyP && (g == n);
        setOv = h && mPend[n] && !drn;
        if (h && (!mPend[n] || drn)) begin
          mCapS[n] = mCount;
          mCapE[n] = mPR[n];
          mPend[n] = 1'b1;
        end else if (drn) begin
          mPend[n] = 1'b0;
        end
        mOv[n] = (mOv[n] && !iOverrunClr[n]) || setOv;
      end
      if (iClear)       mCount = '0;
      else if (iEnable) mCount = mCount + 1'b1;
      s1 = sampleAt(mEdgeNo - S);
      s0 = sampleAt(mEdgeNo - S - 1);
      for (int n = 0; n < N; n++) begin
        nR[n] = s1[n] && !s0[n] && iEdgeMode[2*n];
        nF[n] = !s1[n] && s0[n] && iEdgeMode[2*n+1];
      end
      mPR = nR;
      mPF = nF;
    end
  end

  always @(negedge iCLK) begin
    if (mArmed) begin
      check("model_count", oCount, mCount);
      check("model_valid", oValid, mValid);
      check("model_overrun", oOverrun, mOv);
      if (mValid) begin
        check("model_channel", oChannel, mChan);
        check("model_stamp", oStamp, mStamp);
        check("model_edge", oEdge, mEdgeT);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid(input int budget);
    int k = 0;
    while (oValid !== 1'b1 && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    check("wait_valid", oValid, 1'b1);
  endtask

  task automatic wait_count(input logic [W-1:0] v, input int budget);
    int k = 0;
    while (oCount !== v && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    check("wait_count", oCount, v);
  endtask

  logic [W-1:0] c, stA, stB;

  initial begin
    // Reset state
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    check("reset_count", oCount, 0);
    check("reset_valid", oValid, 0);
    check("reset_overrun", oOverrun, 0);

    // Counter runs for 10 cycles
    iEdgeMode = 8'h55;
    iReady    = 1'b1;
    iEnable   = 1'b1;
    repeat (10) @(negedge iCLK);
    check("count_10", oCount, 10);
    check("count_10_valid", oValid, 0);

    // Channel 1 rising edge sampled at edge 20
    wait_count(8'd19, 20);
    iLatch[1] = 1'b1;
    wait_valid(20);
    check("ch1_latency", oCount, 24);
    check("ch1_channel", oChannel, 1);
    check("ch1_edge", oEdge, 1);
    check("ch1_stamp", oStamp, 22);
    iLatch = '0;
    repeat (5) @(negedge iCLK);

    // Fresh arbiter: channels 0, 2, 3 at once
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    c = oCount;
    iLatch = 4'b1101;
    wait_valid(20);
    check("multi_ch_a", oChannel, 0);
    check("multi_stamp_a", oStamp, c + 8'd3);
    @(negedge iCLK);
    check("multi_valid_b", oValid, 1);
    check("multi_ch_b", oChannel, 2);
    check("multi_stamp_b", oStamp, c + 8'd3);
    @(negedge iCLK);
    check("multi_valid_c", oValid, 1);
    check("multi_ch_c", oChannel, 3);
    check("multi_stamp_c", oStamp, c + 8'd3);
    @(negedge iCLK);
    check("multi_drained", oValid, 0);
    iLatch = '0;
    repeat (5) @(negedge iCLK);

    // Overrun with iReady low: three rising edges on channel 0
    iReady = 1'b0;
    stA = oCount + 8'd3;
    iLatch[0] = 1'b1;
    repeat (4) @(negedge iCLK);
    iLatch[0] = 1'b0;
    repeat (4) @(negedge iCLK);
    stB = oCount + 8'd3;
    iLatch[0] = 1'b1;
    repeat (4) @(negedge iCLK);
    iLatch[0] = 1'b0;
    repeat (4) @(negedge iCLK);
    iLatch[0] = 1'b1;
    repeat (6) @(negedge iCLK);
    check("ovr_flag", oOverrun, 4'b0001);
    check("ovr_valid", oValid, 1);
    check("ovr_first_stamp", oStamp, stA);
    iReady = 1'b1;
    @(negedge iCLK);
    check("ovr_kept_stamp", oStamp, stB);
    check("ovr_kept_channel", oChannel, 0);
    iOverrunClr = 4'b0001;
    @(negedge iCLK);
    iOverrunClr = '0;
    check("ovr_cleared", oOverrun, 0);
    iLatch = '0;
    repeat (5) @(negedge iCLK);

    // Both-edge mode, 1-cycle pulse on channel 2, drained back to back
    iEdgeMode = 8'h75;
    @(negedge iCLK);
    c = oCount;
    iLatch[2] = 1'b1;
    @(negedge iCLK);
    iLatch[2] = 1'b0;
    wait_valid(20);
    check("both_rise_edge", oEdge, 1);
    check("both_rise_stamp", oStamp, c + 8'd3);
    @(negedge iCLK);
    check("both_fall_valid", oValid, 1);
    check("both_fall_edge", oEdge, 0);
    check("both_fall_stamp", oStamp, c + 8'd4);
    check("both_no_overrun", oOverrun, 0);
    iEdgeMode = 8'h55;
    repeat (4) @(negedge iCLK);

    // Clear beats enable, then wrap through 255
    iClear = 1'b1;
    @(negedge iCLK);
    iClear = 1'b0;
    check("clear_count", oCount, 0);
    wait_count(8'd252, 300);
    iLatch[0] = 1'b1;
    repeat (2) @(negedge iCLK);
    iLatch[1] = 1'b1;
    wait_valid(20);
    check("wrap_ch_a", oChannel, 0);
    check("wrap_stamp_a", oStamp, 255);
    @(negedge iCLK);
    wait_valid(20);
    check("wrap_ch_b", oChannel, 1);
    check("wrap_stamp_b", oStamp, 1);
    iLatch = '0;
    repeat (5) @(negedge iCLK);

    // Reset with a held output entry and two channels pending
    iReady = 1'b0;
    iLatch = 4'b0111;
    wait_valid(20);
    repeat (3) @(negedge iCLK);
    iRST   = 1'b1;
    iLatch = '0;
    @(negedge iCLK);
    check("rst_mid_valid", oValid, 0);
    check("rst_mid_count", oCount, 0);
    iRST   = 1'b0;
    iReady = 1'b1;
    repeat (8) @(negedge iCLK);
    check("rst_mid_pending_gone", oValid, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", nFail);
    $fatal(1);
  end

endmodule
